// File: rtl/bram2_be_clr_pkg.sv
// Shared constants for the byte-enabled, self-clearing dual-port BRAM.
package bram2_be_clr_pkg;

  // Same-port read-during-write behaviour
  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  // Clear sequencer states
  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/bram2_be_clr_if.sv
// One BRAM access port: enable, byte-lane write enables, address, write and read data.
interface bram2_be_clr_if #(
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WE_WIDTH   = 1
);
  logic                  EN;
  logic [WE_WIDTH-1:0]   WE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DI;
  logic [DATA_WIDTH-1:0] DO;

  modport master (output EN, WE, ADDR, DI, input DO);
  modport slave  (input EN, WE, ADDR, DI, output DO);
endinterface

// File: rtl/bram2_be_clr_port_ctl.sv
// Per-port datapath: byte-lane merge, read-during-write select and output register stages.
module bram2_be_clr_port_ctl
  import bram2_be_clr_pkg::*;
#(
  parameter int unsigned PIPELINED  = 0,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHUNKSIZE  = 8,
  parameter int unsigned WE_WIDTH   = 1,
  parameter int unsigned RDW_MODE   = RDW_WRITE_FIRST
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [WE_WIDTH-1:0]   we,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] s1_d, s1_q, s2_q;

  // New data in the enabled lanes, stored word everywhere else
  always_comb begin
    merged = rd_word;
    for (int k = 0; k < WE_WIDTH; k++) begin
      if (we[k]) merged[k*CHUNKSIZE +: CHUNKSIZE] = di[k*CHUNKSIZE +: CHUNKSIZE];
    end
  end

  // Stage-1 next value: plain read, or the RDW-mode choice when this port writes
  always_comb begin
    s1_d = s1_q;
    if (en) begin
      if (we == '0) begin
        s1_d = rd_word;
      end else begin
        case (RDW_MODE)
          RDW_WRITE_FIRST: s1_d = merged;
          RDW_READ_FIRST:  s1_d = rd_word;
          default:         s1_d = s1_q;
        endcase
      end
    end
  end

  // Output registers; stage 2 follows stage 1 unconditionally
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  assign dout = (PIPELINED != 0) ? s2_q : s1_q;

endmodule

// File: rtl/bram2_be_clr.sv
// True dual-port BRAM with byte-lane write enables, RDW mode select and a post-reset clear sweep.
module bram2_be_clr
  import bram2_be_clr_pkg::*;
#(
  parameter int unsigned           PIPELINED      = 0,
  parameter int unsigned           ADDR_WIDTH     = 1,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           CHUNKSIZE      = 8,
  parameter int unsigned           WE_WIDTH       = 1,
  parameter int unsigned           MEMSIZE        = 2,
  parameter int unsigned           RDW_MODE       = RDW_WRITE_FIRST,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic          CLK,
  input  logic          RST,
  bram2_be_clr_if.slave porta,
  bram2_be_clr_if.slave portb,
  output logic          BUSY
);

  localparam int unsigned           IdxW     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [ADDR_WIDTH:0]   MemSizeW = (ADDR_WIDTH + 1)'(MEMSIZE);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(MEMSIZE - 1);

  logic [DATA_WIDTH-1:0] ram [MEMSIZE];

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  live;
  logic                  a_in, b_in, a_wr, b_wr, ab_hit;
  logic [DATA_WIDTH-1:0] rd_a, rd_b, merged_a, merged_b, wdata_b;

  assign live = (state_q == StIdle);
  assign BUSY = (state_q == StClear);

  assign a_in = {1'b0, porta.ADDR} < MemSizeW;
  assign b_in = {1'b0, portb.ADDR} < MemSizeW;
  assign rd_a = a_in ? ram[IdxW'(porta.ADDR)] : 'x;
  assign rd_b = b_in ? ram[IdxW'(portb.ADDR)] : 'x;

  assign a_wr   = live && porta.EN && a_in && (|porta.WE);
  assign b_wr   = live && portb.EN && b_in && (|portb.WE);
  assign ab_hit = a_wr && b_wr && (porta.ADDR == portb.ADDR);

  // Shared address: B's lanes win, A's lanes survive wherever B is silent
  always_comb begin
    wdata_b = merged_b;
    if (ab_hit) begin
      for (int k = 0; k < WE_WIDTH; k++) begin
        if (porta.WE[k] && !portb.WE[k]) begin
          wdata_b[k*CHUNKSIZE +: CHUNKSIZE] = porta.DI[k*CHUNKSIZE +: CHUNKSIZE];
        end
      end
    end
  end

  // RAM write path; the clear sweep owns it while busy, and contents are never reset
  always_ff @(posedge CLK) begin
    if (!live) begin
      ram[IdxW'(cnt_q)] <= CLEAR_VALUE;
    end else begin
      if (a_wr && !ab_hit) ram[IdxW'(porta.ADDR)] <= merged_a;
      if (b_wr)            ram[IdxW'(portb.ADDR)] <= wdata_b;
    end
  end

  // Clear sequencer: one word per cycle, then idle until the next reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
      cnt_q   <= '0;
    end else if (state_q == StClear) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastIdx) state_q <= StIdle;
    end
  end

  bram2_be_clr_port_ctl #(
    .PIPELINED  (PIPELINED),
    .DATA_WIDTH (DATA_WIDTH),
    .CHUNKSIZE  (CHUNKSIZE),
    .WE_WIDTH   (WE_WIDTH),
    .RDW_MODE   (RDW_MODE)
  ) u_port_a (
    .CLK     (CLK),
    .RST     (RST),
    .en      (live && porta.EN),
    .we      (porta.WE),
    .di      (porta.DI),
    .rd_word (rd_a),
    .merged  (merged_a),
    .dout    (porta.DO)
  );

  bram2_be_clr_port_ctl #(
    .PIPELINED  (PIPELINED),
    .DATA_WIDTH (DATA_WIDTH),
    .CHUNKSIZE  (CHUNKSIZE),
    .WE_WIDTH   (WE_WIDTH),
    .RDW_MODE   (RDW_MODE)
  ) u_port_b (
    .CLK     (CLK),
    .RST     (RST),
    .en      (live && portb.EN),
    .we      (portb.WE),
    .di      (portb.DI),
    .rd_word (rd_b),
    .merged  (merged_b),
    .dout    (portb.DO)
  );

endmodule

// File: tb/tb_bram2_be_clr.sv
// Bench: six instances (RDW mode 0/1/2 x PIPELINED 0/1) share one stimulus stream and a word-level model.
module tb_bram2_be_clr;

  localparam int          MEM = 16;
  localparam logic [31:0] CLR = 32'hA5A5_A5A5;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [4:0]  addra = '0, addrb = '0;
  logic [31:0] dia = '0, dib = '0;

  logic [31:0] doa_w [6];
  logic [31:0] dob_w [6];
  logic        busy_w [6];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    bram2_be_clr_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WE_WIDTH(4)) ifa ();
    bram2_be_clr_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WE_WIDTH(4)) ifb ();
    assign ifa.EN   = ena;
    assign ifa.WE   = wea;
    assign ifa.ADDR = addra;
    assign ifa.DI   = dia;
    assign ifb.EN   = enb;
    assign ifb.WE   = web;
    assign ifb.ADDR = addrb;
    assign ifb.DI   = dib;
    assign doa_w[g] = ifa.DO;
    assign dob_w[g] = ifb.DO;

    bram2_be_clr #(
      .PIPELINED      (g / 3),
      .ADDR_WIDTH     (5),
      .DATA_WIDTH     (32),
      .CHUNKSIZE      (8),
      .WE_WIDTH       (4),
      .MEMSIZE        (MEM),
      .RDW_MODE       (g % 3),
      .CLEAR_ON_RESET (1),
      .CLEAR_VALUE    (CLR)
    ) u_dut (
      .CLK   (CLK),
      .RST   (RST),
      .porta (ifa.slave),
      .portb (ifb.slave),
      .BUSY  (busy_w[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem [MEM];
  bit          mk  [MEM];
  int          sweep_left = 0;
  logic [31:0] s1a [6], s2a [6], s1b [6], s2b [6];
  bit          k1a [6], k2a [6], k1b [6], k2b [6];

  // Returns {known, value} of a port's first output stage after one clock
  function automatic logic [32:0] next_s1(input int mode, input logic en, input logic [3:0] we,
                                          input logic [31:0] di, input logic [31:0] old,
                                          input logic oldk, input logic [31:0] cur,
                                          input logic curk);
    logic [31:0] w;
    if (!en) return {curk, cur};
    if (we == 4'h0) return {oldk, old};
    if (mode == 1) return {oldk, old};
    if (mode == 2) return {curk, cur};
    w = old;
    for (int k = 0; k < 4; k++) if (we[k]) w[k*8 +: 8] = di[k*8 +: 8];
    return {oldk, w};
  endfunction

  initial forever begin
    logic        a_in, b_in, oka, okb;
    logic [31:0] olda, oldb;
    @(posedge CLK or posedge RST);
    if (RST) begin
      sweep_left = MEM;
      for (int g = 0; g < 6; g++) begin
        s1a[g] = '0; s2a[g] = '0; s1b[g] = '0; s2b[g] = '0;
        k1a[g] = 1;  k2a[g] = 1;  k1b[g] = 1;  k2b[g] = 1;
      end
    end else if (sweep_left != 0) begin
      mem[MEM - sweep_left] = CLR;
      mk[MEM - sweep_left]  = 1;
      sweep_left--;
      for (int g = 0; g < 6; g++) begin
        s2a[g] = s1a[g]; k2a[g] = k1a[g]; s2b[g] = s1b[g]; k2b[g] = k1b[g];
      end
    end else begin
      a_in = addra < 5'(MEM);
      b_in = addrb < 5'(MEM);
      olda = a_in ? mem[addra[3:0]] : '0;
      oldb = b_in ? mem[addrb[3:0]] : '0;
      oka  = a_in && mk[addra[3:0]];
      okb  = b_in && mk[addrb[3:0]];
      for (int g = 0; g < 6; g++) begin
        s2a[g] = s1a[g]; k2a[g] = k1a[g]; s2b[g] = s1b[g]; k2b[g] = k1b[g];
        {k1a[g], s1a[g]} = next_s1(g % 3, ena, wea, dia, olda, oka, s1a[g], k1a[g]);
        {k1b[g], s1b[g]} = next_s1(g % 3, enb, web, dib, oldb, okb, s1b[g], k1b[g]);
      end
      // A first, then B, so B wins any lane both touch
      if (ena && a_in)
        for (int k = 0; k < 4; k++) if (wea[k]) mem[addra[3:0]][k*8 +: 8] = dia[k*8 +: 8];
      if (enb && b_in)
        for (int k = 0; k < 4; k++) if (web[k]) mem[addrb[3:0]][k*8 +: 8] = dib[k*8 +: 8];
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge CLK);
    #1;
    if (chk_en) begin
      for (int g = 0; g < 6; g++) begin
        chk($sformatf("busy[%0d]", g), {31'b0, busy_w[g]}, {31'b0, sweep_left != 0});
        if (g / 3 == 0) begin
          if (k1a[g]) chk($sformatf("doa[%0d]", g), doa_w[g], s1a[g]);
          if (k1b[g]) chk($sformatf("dob[%0d]", g), dob_w[g], s1b[g]);
        end else begin
          if (k2a[g]) chk($sformatf("doa[%0d]", g), doa_w[g], s2a[g]);
          if (k2b[g]) chk($sformatf("dob[%0d]", g), dob_w[g], s2b[g]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic a_en, input logic [3:0] a_we, input logic [4:0] a_ad,
                    input logic [31:0] a_di, input logic b_en, input logic [3:0] b_we,
                    input logic [4:0] b_ad, input logic [31:0] b_di);
    ena = a_en; wea = a_we; addra = a_ad; dia = a_di;
    enb = b_en; web = b_we; addrb = b_ad; dib = b_di;
    @(negedge CLK);
  endtask

  task automatic nop();
    op(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
  endtask

  task automatic wr_a(input logic [4:0] ad, input logic [3:0] we, input logic [31:0] di);
    op(1'b1, we, ad, di, 1'b0, 4'h0, 5'd0, 32'h0);
  endtask

  task automatic rd_a(input logic [4:0] ad);
    op(1'b1, 4'h0, ad, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy_w[0] && n < 40) begin
      n++;
      @(negedge CLK);
    end
    chk(name, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge CLK);
    // Reset and first clear sweep
    RST = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy_w[0]}, 32'd1);
    chk("rst_doa", doa_w[0], 32'h0);
    chk("rst_dob_pipe", dob_w[3], 32'h0);
    @(negedge CLK);
    RST    = 1'b0;
    chk_en = 1'b1;
    count_busy("busy_cycles");

    for (int i = 0; i < MEM; i++) rd_a(5'(i));
    chk("clear_last", doa_w[0], CLR);
    nop();
    chk("clear_last_pipe", doa_w[3], CLR);
    op(1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 4'h0, 5'd0, 32'h0);
    chk("clear_b0", dob_w[0], CLR);

    // Byte-lane merge
    wr_a(5'd2, 4'hF, 32'hAAAA_AAAA);
    wr_a(5'd2, 4'b0101, 32'h1122_3344);
    chk("wf_merge", doa_w[0], 32'hAA22_AA44);
    chk("rf_merge", doa_w[1], 32'hAAAA_AAAA);
    rd_a(5'd2);
    chk("merge_read", doa_w[0], 32'hAA22_AA44);
    chk("merge_read_nc", doa_w[2], 32'hAA22_AA44);

    // RDW modes, then one cycle later for the pipelined set
    wr_a(5'd4, 4'hF, 32'h0);
    rd_a(5'd2);
    wr_a(5'd4, 4'hF, 32'h5A5A_5A5A);
    chk("rdw_wf", doa_w[0], 32'h5A5A_5A5A);
    chk("rdw_rf", doa_w[1], 32'h0);
    chk("rdw_nc", doa_w[2], 32'hAA22_AA44);
    nop();
    chk("rdw_wf_pipe", doa_w[3], 32'h5A5A_5A5A);
    chk("rdw_rf_pipe", doa_w[4], 32'h0);
    chk("rdw_nc_pipe", doa_w[5], 32'hAA22_AA44);

    // Both ports write one address
    op(1'b1, 4'hF, 5'd3, 32'h0101_0101, 1'b1, 4'hF, 5'd3, 32'h0202_0202);
    chk("coll_wf_a", doa_w[0], 32'h0101_0101);
    chk("coll_wf_b", dob_w[0], 32'h0202_0202);
    chk("coll_rf_a", doa_w[1], CLR);
    rd_a(5'd3);
    chk("coll_b_wins", doa_w[0], 32'h0202_0202);
    op(1'b1, 4'b0011, 5'd6, 32'h1111_1111, 1'b1, 4'b1100, 5'd6, 32'h2222_2222);
    op(1'b1, 4'b0110, 5'd6, 32'h3333_3333, 1'b1, 4'b0011, 5'd6, 32'h4444_4444);
    rd_a(5'd6);
    chk("lanes_mixed", doa_w[0], 32'h2233_4444);

    // B writes while A reads the same word
    wr_a(5'd5, 4'hF, 32'h0);
    op(1'b1, 4'h0, 5'd5, 32'h0, 1'b1, 4'hF, 5'd5, 32'hFFFF_FFFF);
    chk("xport_old", doa_w[0], 32'h0);
    rd_a(5'd5);
    chk("xport_new", doa_w[0], 32'hFFFF_FFFF);

    // Disabled write and out-of-range write must not land
    op(1'b0, 4'hF, 5'd0, 32'h1234_5678, 1'b0, 4'h0, 5'd0, 32'h0);
    wr_a(5'd16, 4'hF, 32'h7777_7777);
    rd_a(5'd0);
    chk("no_alias", doa_w[0], CLR);
    nop();

    // Reset with live outputs, then reset again mid-sweep while port A keeps writing
    RST = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) chk($sformatf("rst2_doa[%0d]", g), doa_w[g], 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 7; i++) wr_a(5'd1, 4'hF, 32'hDEAD_BEEF);
    RST = 1'b1;
    #1;
    chk("rst3_busy", {31'b0, busy_w[0]}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    count_busy("busy_cycles_restart");
    rd_a(5'd1);
    chk("busy_write_lost", doa_w[0], CLR);
    rd_a(5'd2);
    chk("reclear", doa_w[0], CLR);
    nop();
    nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
